// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and helpers for the 4-way L1 data cache.
//   Geometry constants (line offset, word select, way count), FSM state
//   encodings, tree-PLRU victim/update functions, line word get/merge helpers.
package cache_pkg;

  localparam int OFFSET_W = 5;    // byte offset within a 32-byte line
  localparam int WORD_W   = 3;    // word select within a line
  localparam int WAYS     = 4;
  localparam int WAY_W    = 2;
  localparam int LINE_W   = 256;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WB        = 3'd1;
  localparam logic [2:0] ST_FILL_REQ  = 3'd2;
  localparam logic [2:0] ST_FILL_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // Lowest-numbered invalid way wins; only a full set consults the tree.
  // lru[0]=1 points at the 2/3 half, lru[1]/lru[2] pick within each half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] lru,
                                                   input logic [3:0] valid);
    logic [WAY_W-1:0] v;
    if (!valid[0])      v = 2'd0;
    else if (!valid[1]) v = 2'd1;
    else if (!valid[2]) v = 2'd2;
    else if (!valid[3]) v = 2'd3;
    else if (lru[0])    v = lru[2] ? 2'd3 : 2'd2;
    else                v = lru[1] ? 2'd1 : 2'd0;
    return v;
  endfunction

  // Point the tree away from the way just touched.
  function automatic logic [2:0] plru_update(input logic [2:0] lru,
                                             input logic [WAY_W-1:0] way);
    logic [2:0] n;
    n = lru;
    if (!way[1]) begin
      n[0] = 1'b1;
      n[1] = (way == 2'd0);
    end else begin
      n[0] = 1'b0;
      n[2] = (way == 2'd2);
    end
    return n;
  endfunction

  function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                           input logic [WORD_W-1:0] w);
    logic [7:0] base;
    base = {w, 5'b0};
    return line[base +: 32];
  endfunction

  // Overwrite the enabled bytes of word w inside a line.
  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] w,
                                                   input logic [3:0]        be,
                                                   input logic [31:0]       wd);
    logic [LINE_W-1:0] l;
    logic [7:0]        base;
    l    = line;
    base = {w, 5'b0};
    if (be[0]) l[base          +: 8] = wd[7:0];
    if (be[1]) l[base + 8'd8   +: 8] = wd[15:8];
    if (be[2]) l[base + 8'd16  +: 8] = wd[23:16];
    if (be[3]) l[base + 8'd24  +: 8] = wd[31:24];
    return l;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// cache_plru: combinational tree-PLRU helper for one set.
//   Ports: lru/valid = current set state, way = way being accessed;
//   victim = way to replace on a miss, lru_next = tree after accessing 'way'.
module cache_plru
  import cache_pkg::*;
(
  input  logic [2:0]       lru,
  input  logic [3:0]       valid,
  input  logic [WAY_W-1:0] way,
  output logic [WAY_W-1:0] victim,
  output logic [2:0]       lru_next
);

  assign victim   = plru_victim(lru, valid);
  assign lru_next = plru_update(lru, way);

endmodule

// File: rtl/l1_cache_4way.sv
// l1_cache_4way: write-back, write-allocate, 4-way set-associative L1 data
//   cache, 32-byte lines, tree PLRU, one request in flight at a time.
// Ports: master_clk/reset (sync, active-high); requester a/be/read/write/wd in,
//   rd/rd_valid/req_hit out; memory mm_a/mm_wd/mm_write/mm_read out, mm_rd/mm_valid in.
//   ram_test is used only when CACHE_RAM_TEST_EN is defined (tag-RAM test access).
module l1_cache_4way
  import cache_pkg::*;
#(
  parameter int SETS = 8192
) (
  input  logic         master_clk,
  input  logic         reset,
  input  logic [31:0]  a,
  input  logic [3:0]   be,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  wd,
  input  logic         ram_test,
  output logic [31:0]  rd,
  output logic         rd_valid,
  output logic         req_hit,
  output logic [31:0]  mm_a,
  output logic [255:0] mm_wd,
  output logic         mm_write,
  output logic         mm_read,
  input  logic [255:0] mm_rd,
  input  logic         mm_valid
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - IDX_W;
  localparam int PAD_W = 21 - TAG_W;   // zero fill in the tag-RAM test readout

  // Tag and data arrays carry no reset; valid/mod/lru are flops cleared at reset.
  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [LINE_W-1:0] data_arr [WAYS][SETS];
  logic [SETS-1:0][3:0] valid_arr;
  logic [SETS-1:0][3:0] mod_arr;
  logic [SETS-1:0][2:0] lru_arr;

  logic [2:0]        state;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req_wr;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic [WAY_W-1:0]  req_way;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [WORD_W-1:0] a_word;
  logic [WAY_W-1:0]  rt_way;
  logic              is_write;
  logic              idle_req;
  logic              rt_req;

  assign a_tag    = a[31 -: TAG_W];
  assign a_idx    = a[OFFSET_W +: IDX_W];
  assign a_word   = a[4:2];
  assign rt_way   = a[1:0];
  assign is_write = write & ~read;      // read wins when both are raised
  assign idle_req = (state == ST_IDLE) && (read || write);

`ifdef CACHE_RAM_TEST_EN
  assign rt_req = ram_test;
`else
  logic unused_ram_test;
  assign unused_ram_test = ram_test;
  assign rt_req = 1'b0;
`endif

  // Set state: the incoming request's set while idle, the latched one otherwise.
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]       set_valid;
  logic [3:0]       set_mod;
  logic [2:0]       set_lru;

  assign cur_idx   = (state == ST_IDLE) ? a_idx : req_idx;
  assign set_valid = valid_arr[cur_idx];
  assign set_mod   = mod_arr[cur_idx];
  assign set_lru   = lru_arr[cur_idx];

  // Combinational tag compare in the request cycle.
  logic [3:0]       hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;

  assign hit_vec[0] = set_valid[0] && (tag_arr[0][a_idx] == a_tag);
  assign hit_vec[1] = set_valid[1] && (tag_arr[1][a_idx] == a_tag);
  assign hit_vec[2] = set_valid[2] && (tag_arr[2][a_idx] == a_tag);
  assign hit_vec[3] = set_valid[3] && (tag_arr[3][a_idx] == a_tag);
  assign hit        = |hit_vec;

  always_comb begin
    hit_way = 2'd0;
    if      (hit_vec[0]) hit_way = 2'd0;
    else if (hit_vec[1]) hit_way = 2'd1;
    else if (hit_vec[2]) hit_way = 2'd2;
    else if (hit_vec[3]) hit_way = 2'd3;
  end

  // One PLRU instance serves both the hit update (idle) and the fill update.
  logic [WAY_W-1:0] acc_way;
  logic [WAY_W-1:0] victim;
  logic [2:0]       lru_next;

  assign acc_way = (state == ST_IDLE) ? hit_way : req_way;

  cache_plru u_plru (
    .lru      (set_lru),
    .valid    (set_valid),
    .way      (acc_way),
    .victim   (victim),
    .lru_next (lru_next)
  );

  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] vic_line;
  logic [TAG_W-1:0]  vic_tag;
  logic              vic_dirty;

  assign hit_line  = data_arr[hit_way][a_idx];
  assign vic_line  = data_arr[victim][a_idx];
  assign vic_tag   = tag_arr[victim][a_idx];
  assign vic_dirty = set_valid[victim] & set_mod[victim];

  logic rt_wr;
  logic hit_wr;
  logic fill_take;

  assign rt_wr     = idle_req && rt_req && is_write;
  assign hit_wr    = idle_req && !rt_req && hit && is_write;
  assign fill_take = (state == ST_FILL_WAIT) && mm_valid;

  // Tag and data array writes.
  always_ff @(posedge master_clk) begin
    if (!reset) begin
      if (rt_wr) begin
        tag_arr[rt_way][a_idx] <= wd[TAG_W-1:0];
      end else if (hit_wr) begin
        data_arr[hit_way][a_idx] <= merge_word(hit_line, a_word, be, wd);
      end else if (fill_take) begin
        tag_arr[req_way][req_idx]  <= req_tag;
        data_arr[req_way][req_idx] <= req_wr ? merge_word(mm_rd, req_word, req_be, req_wd)
                                             : mm_rd;
      end
    end
  end

  // Control FSM, set state flops and registered outputs.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      valid_arr <= '0;
      mod_arr   <= '0;
      lru_arr   <= '0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_word  <= '0;
      req_wr    <= 1'b0;
      req_be    <= '0;
      req_wd    <= '0;
      req_way   <= '0;
      rd        <= '0;
      rd_valid  <= 1'b0;
      req_hit   <= 1'b0;
      mm_a      <= '0;
      mm_wd     <= '0;
      mm_write  <= 1'b0;
      mm_read   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      req_hit  <= 1'b0;
      mm_write <= 1'b0;
      mm_read  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read || write) begin
            req_tag  <= a_tag;
            req_idx  <= a_idx;
            req_word <= a_word;
            req_wr   <= is_write;
            req_be   <= be;
            req_wd   <= wd;
            if (rt_req) begin
              // Direct tag-RAM access to way a[1:0]; no memory traffic.
              if (is_write) begin
                valid_arr[a_idx][rt_way] <= 1'b1;
                mod_arr[a_idx][rt_way]   <= 1'b0;
              end else begin
                rd       <= {set_valid, set_mod, set_lru, {PAD_W{1'b0}}, tag_arr[rt_way][a_idx]};
                rd_valid <= 1'b1;
              end
            end else if (hit) begin
              req_hit        <= 1'b1;
              lru_arr[a_idx] <= lru_next;
              if (is_write) begin
                mod_arr[a_idx][hit_way] <= 1'b1;
              end else begin
                rd       <= get_word(hit_line, a_word);
                rd_valid <= 1'b1;
              end
            end else begin
              req_way <= victim;
              if (vic_dirty) begin
                state    <= ST_WB;
                mm_write <= 1'b1;
                mm_a     <= {vic_tag, a_idx, {OFFSET_W{1'b0}}};
                mm_wd    <= vic_line;
              end else begin
                state   <= ST_FILL_REQ;
                mm_read <= 1'b1;
                mm_a    <= {a_tag, a_idx, {OFFSET_W{1'b0}}};
              end
            end
          end
        end
        ST_WB: begin
          state   <= ST_FILL_REQ;
          mm_read <= 1'b1;
          mm_a    <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
        end
        ST_FILL_REQ: begin
          state <= ST_FILL_WAIT;
        end
        ST_FILL_WAIT: begin
          if (mm_valid) begin
            valid_arr[req_idx][req_way] <= 1'b1;
            mod_arr[req_idx][req_way]   <= req_wr;
            lru_arr[req_idx]            <= lru_next;
            if (!req_wr) begin
              rd       <= get_word(mm_rd, req_word);
              rd_valid <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cache_4way.sv
module tb_l1_cache_4way;

  logic         master_clk = 1'b0;
  logic         reset;
  logic [31:0]  a;
  logic [3:0]   be;
  logic         read;
  logic         write;
  logic [31:0]  wd;
  logic         ram_test;
  logic [31:0]  rd;
  logic         rd_valid;
  logic         req_hit;
  logic [31:0]  mm_a;
  logic [255:0] mm_wd;
  logic         mm_write;
  logic         mm_read;
  logic [255:0] mm_rd;
  logic         mm_valid;

  always #5 master_clk = ~master_clk;

  l1_cache_4way dut (
    .master_clk (master_clk),
    .reset      (reset),
    .a          (a),
    .be         (be),
    .read       (read),
    .write      (write),
    .wd         (wd),
    .ram_test   (ram_test),
    .rd         (rd),
    .rd_valid   (rd_valid),
    .req_hit    (req_hit),
    .mm_a       (mm_a),
    .mm_wd      (mm_wd),
    .mm_write   (mm_write),
    .mm_read    (mm_read),
    .mm_rd      (mm_rd),
    .mm_valid   (mm_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic        rt;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        exp_hit;
    logic        exp_rdv;
    logic [31:0] exp_rd;
    logic        exp_mmr;
    logic [31:0] exp_mmr_a;
    logic        exp_mmw;
    logic [31:0] exp_mmw_a;
    logic [31:0] exp_mmw_w0;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0]  exp_q [$];
  logic [255:0] mem [logic [31:0]];
  vec_t tbl [18];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Memory model: lines never written back read as word k = line_addr + k.
  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem.exists(la)) return mem[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = la + 32'(k);
    return l;
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] ctl,
                              input logic [3:0] b, input logic [31:0] d,
                              input logic [1:0] hv, input logic [31:0] erd,
                              input logic [1:0] mm, input logic [31:0] mra,
                              input logic [31:0] mwa, input logic [31:0] mw0);
    vec_t v;
    v.addr = addr; v.rd_en = ctl[2]; v.wr_en = ctl[1]; v.rt = ctl[0];
    v.be = b; v.wd = d; v.exp_hit = hv[1]; v.exp_rdv = hv[0]; v.exp_rd = erd;
    v.exp_mmr = mm[1]; v.exp_mmr_a = mra; v.exp_mmw = mm[0];
    v.exp_mmw_a = mwa; v.exp_mmw_w0 = mw0;
    return v;
  endfunction

  // Drive one request, act as main memory, collect responses, compare.
  task automatic run_row(input vec_t v, input string nm);
    bit got_hit, got_rdv, pend, done;
    int n_mmr, n_mmw, mmr_cyc, mmv_cyc, rdv_cyc, lat, cyc;
    logic [31:0] mmr_a, mmw_a, mmw_w0, fill_a;
    got_hit = 0; got_rdv = 0; pend = 0; done = 0;
    n_mmr = 0; n_mmw = 0; mmr_cyc = -1; mmv_cyc = -1; rdv_cyc = -1; lat = 0;
    mmr_a = '0; mmw_a = '0; mmw_w0 = '0; fill_a = '0;
    @(negedge master_clk);
    a = v.addr; read = v.rd_en; write = v.wr_en; ram_test = v.rt; be = v.be; wd = v.wd;
    if (v.exp_rdv) exp_q.push_back(v.exp_rd);
    @(negedge master_clk);
    read = 0; write = 0; ram_test = 0;
    cyc = 0;
    while (!done && cyc < 300) begin
      if (mm_valid) begin
        mm_valid = 0;
        if (v.wr_en && !v.rd_en) done = 1;
      end
      if (req_hit) begin
        got_hit = 1;
        if (v.wr_en && !v.rd_en) done = 1;
      end
      if (rd_valid) begin
        got_rdv = 1; rdv_cyc = cyc; done = 1;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL %s_rd: unexpected rd_valid with rd %h, none required", nm, rd);
        end else begin
          check({nm, "_rd"}, rd, exp_q.pop_front());
        end
      end
      if (mm_write) begin
        n_mmw++; mmw_a = mm_a; mmw_w0 = mm_wd[31:0];
        mem[mm_a] = mm_wd;
      end
      if (mm_read) begin
        n_mmr++; mmr_cyc = cyc; mmr_a = mm_a; fill_a = mm_a; pend = 1; lat = 2;
      end else if (pend) begin
        if (lat == 0) begin
          mm_rd = mem_line(fill_a); mm_valid = 1; pend = 0; mmv_cyc = cyc;
        end else lat--;
      end
      if (v.rt && v.wr_en && cyc >= 1) done = 1;
      if (!done) begin
        @(negedge master_clk);
        cyc++;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: request not complete after %0d cycles", nm, cyc);
    end
    exp_q.delete();
    check({nm, "_hit"}, 32'(got_hit), 32'(v.exp_hit));
    check({nm, "_rdv"}, 32'(got_rdv), 32'(v.exp_rdv));
    check({nm, "_mmr_n"}, n_mmr, 32'(v.exp_mmr));
    check({nm, "_mmw_n"}, n_mmw, 32'(v.exp_mmw));
    if (v.exp_hit && v.exp_rdv) check({nm, "_hit_lat"}, rdv_cyc, 0);
    if (v.exp_mmr) begin
      check({nm, "_mmr_a"}, mmr_a, v.exp_mmr_a);
      check({nm, "_mmr_lat"}, mmr_cyc, v.exp_mmw ? 1 : 0);
      if (v.exp_rdv) check({nm, "_fill_lat"}, rdv_cyc, mmv_cyc + 1);
    end
    if (v.exp_mmw) begin
      check({nm, "_mmw_a"}, mmw_a, v.exp_mmw_a);
      check({nm, "_mmw_w0"}, mmw_w0, v.exp_mmw_w0);
    end
  endtask

  task automatic check_outs_zero(input string nm);
    check({nm, "_strobes"}, {28'b0, rd_valid, req_hit, mm_write, mm_read}, 32'h0);
    check({nm, "_rd"}, rd, 32'h0);
    check({nm, "_mm_a"}, mm_a, 32'h0);
    check({nm, "_mm_wd"}, 32'(|mm_wd), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge master_clk);
    reset = 1;
    @(negedge master_clk);
    reset = 0;
  endtask

  initial begin
    logic [255:0] l;
    reset = 1; a = '0; be = '0; read = 0; write = 0; wd = '0; ram_test = 0;
    mm_rd = '0; mm_valid = 0;
    l = mem_line(32'h100);
    l[63:32] = 32'hDEADBEEF;
    mem[32'h100] = l;

    //            addr          rd/wr/rt be     wd             hit/rdv rd            mmr/mmw mmr_a         mmw_a  mmw_w0
    tbl[0]  = mk(32'h00000104, 3'b100, 4'h0, 32'h0,        2'b01, 32'hDEADBEEF, 2'b10, 32'h00000100, 32'h0, 32'h0);
    tbl[1]  = mk(32'h00000104, 3'b100, 4'h0, 32'h0,        2'b11, 32'hDEADBEEF, 2'b00, 32'h0,        32'h0, 32'h0);
    tbl[2]  = mk(32'h0000010C, 3'b100, 4'h0, 32'h0,        2'b11, 32'h00000103, 2'b00, 32'h0,        32'h0, 32'h0);
    tbl[3]  = mk(32'h00000104, 3'b010, 4'h3, 32'h12345678, 2'b10, 32'h0,        2'b00, 32'h0,        32'h0, 32'h0);
    tbl[4]  = mk(32'h00000104, 3'b100, 4'h0, 32'h0,        2'b11, 32'hDEAD5678, 2'b00, 32'h0,        32'h0, 32'h0);
    tbl[5]  = mk(32'h00000104, 3'b110, 4'hF, 32'hFFFFFFFF, 2'b11, 32'hDEAD5678, 2'b00, 32'h0,        32'h0, 32'h0);
    tbl[6]  = mk(32'h00000104, 3'b100, 4'h0, 32'h0,        2'b11, 32'hDEAD5678, 2'b00, 32'h0,        32'h0, 32'h0);
    tbl[7]  = mk(32'h00000000, 3'b010, 4'hF, 32'hCAFEF00D, 2'b00, 32'h0,        2'b10, 32'h00000000, 32'h0, 32'h0);
    tbl[8]  = mk(32'h00040000, 3'b100, 4'h0, 32'h0,        2'b01, 32'h00040000, 2'b10, 32'h00040000, 32'h0, 32'h0);
    tbl[9]  = mk(32'h00080000, 3'b100, 4'h0, 32'h0,        2'b01, 32'h00080000, 2'b10, 32'h00080000, 32'h0, 32'h0);
    tbl[10] = mk(32'h000C0000, 3'b100, 4'h0, 32'h0,        2'b01, 32'h000C0000, 2'b10, 32'h000C0000, 32'h0, 32'h0);
    tbl[11] = mk(32'h00100000, 3'b100, 4'h0, 32'h0,        2'b01, 32'h00100000, 2'b11, 32'h00100000, 32'h0, 32'hCAFEF00D);
    tbl[12] = mk(32'h00000000, 3'b100, 4'h0, 32'h0,        2'b01, 32'hCAFEF00D, 2'b10, 32'h00000000, 32'h0, 32'h0);
    tbl[13] = mk(32'h00080000, 3'b100, 4'h0, 32'h0,        2'b01, 32'h00080000, 2'b10, 32'h00080000, 32'h0, 32'h0);
    tbl[14] = mk(32'h000C0000, 3'b100, 4'h0, 32'h0,        2'b11, 32'h000C0000, 2'b00, 32'h0,        32'h0, 32'h0);
    tbl[15] = mk(32'h00040000, 3'b100, 4'h0, 32'h0,        2'b01, 32'h00040000, 2'b10, 32'h00040000, 32'h0, 32'h0);
    tbl[16] = mk(32'h000C0004, 3'b010, 4'h8, 32'hAA000000, 2'b10, 32'h0,        2'b00, 32'h0,        32'h0, 32'h0);
    tbl[17] = mk(32'h000C0004, 3'b100, 4'h0, 32'h0,        2'b11, 32'hAA0C0001, 2'b00, 32'h0,        32'h0, 32'h0);

    repeat (2) @(negedge master_clk);
    check_outs_zero("reset");
    reset = 0;

    for (int i = 0; i < 18; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Reset while waiting for a fill: outputs clear, stale fill data ignored,
    // and the set state is gone so 0x104 misses again.
    @(negedge master_clk);
    a = 32'h00002000; read = 1; be = '0;
    @(negedge master_clk);
    read = 0;
    check("rstfw_mm_read", 32'(mm_read), 32'h1);
    check("rstfw_mm_a", mm_a, 32'h00002000);
    repeat (3) @(negedge master_clk);
    reset = 1;
    @(negedge master_clk);
    reset = 0;
    check_outs_zero("rstfw");
    mm_rd = mem_line(32'h00002000); mm_valid = 1;
    @(negedge master_clk);
    mm_valid = 0;
    @(negedge master_clk);
    check("rstfw_ignored_valid", {30'b0, rd_valid, req_hit}, 32'h0);
    run_row(mk(32'h00000104, 3'b100, 4'h0, 32'h0, 2'b01, 32'hDEADBEEF, 2'b10,
               32'h00000100, 32'h0, 32'h0), "post_rst");

`ifdef CACHE_RAM_TEST_EN
    do_reset();
    run_row(mk(32'h00000002, 3'b011, 4'h0, 32'h00001ABC, 2'b00, 32'h0, 2'b00,
               32'h0, 32'h0, 32'h0), "rt_wr");
    run_row(mk(32'h00000002, 3'b101, 4'h0, 32'h0, 2'b01, 32'h40001ABC, 2'b00,
               32'h0, 32'h0, 32'h0), "rt_rd");
`else
    do_reset();
    run_row(mk(32'h00000104, 3'b101, 4'h0, 32'h0, 2'b01, 32'hDEADBEEF, 2'b10,
               32'h00000100, 32'h0, 32'h0), "rt_ignored");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
